mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the CPU's single memory port between the instruction-fetch requester (IF) and the load/store requester (LS).
- Sits between the core pipeline and the memory/MMIO block, which includes the UART register window.
- Holds at most one outstanding transaction. Arbitration is LS-priority with a starvation bound that guarantees fetch progress.
- Exports a stall indication for the next-PC logic.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width; strobe width is DATA_W/8
- MAX_LS_BURST, 4, maximum consecutive LS grants while IF is waiting; must be at least 1

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- if_req  in  1  fetch request; held with if_addr until if_gnt
- if_addr  in  ADDR_W  fetch address
- if_gnt  out  1  fetch accepted by memory this cycle
- if_rvalid  out  1  fetch data valid, one-cycle pulse
- if_rdata  out  DATA_W  fetch data
- ls_req  in  1  load/store request; held with payload until ls_gnt
- ls_we  in  1  1 = store, 0 = load
- ls_addr  in  ADDR_W  load/store address
- ls_wdata  in  DATA_W  store data
- ls_wstrb  in  DATA_W/8  store byte enables
- ls_gnt  out  1  load/store accepted by memory this cycle
- ls_rvalid  out  1  load data valid, one-cycle pulse; never pulses for stores
- ls_rdata  out  DATA_W  load data
- mem_req  out  1  memory request
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_wstrb  out  DATA_W/8  memory byte enables
- mem_ready  in  1  memory accepts the request this cycle
- mem_rvalid  in  1  memory read data valid
- mem_rdata  in  DATA_W  memory read data
- is_stall  out  1  a requester has req high and no gnt this cycle

Behaviour:
- Reset:
  - Outputs: all registered outputs are 0. FSM in IDLE, starvation counter 0, owner = NONE.
  - Reset asserted mid-transaction aborts immediately: mem_req drops and no gnt or rvalid is issued.
  - A mem_rvalid arriving after reset, in IDLE, is ignored.
- FSM states: IDLE, REQ, WAIT.
- IDLE:
  - If either req is high, pick a winner.
  - Latch the winner's payload into mem_* registers and set owner. Go to REQ.
  - For fetch: mem_we = 0, mem_wstrb = all ones.
- Winner selection:
  - Only one requester high: that requester wins.
  - Both high: LS wins, unless the starvation counter equals MAX_LS_BURST, in which case IF wins.
- Starvation counter:
  - Increments on each LS win taken while if_req is high.
  - Clears on any IF win, or whenever if_req is low in IDLE.
  - Saturates at MAX_LS_BURST.
- REQ:
  - mem_req = 1 and mem_* outputs are stable.
  - When mem_ready = 1: the owner's gnt pulses this same cycle (combinational from mem_ready and state) and mem_req drops next cycle.
  - If the transaction is a store, go to IDLE; otherwise go to WAIT.
  - While mem_ready = 0, remain in REQ indefinitely with the payload unchanged.
- WAIT:
  - mem_req = 0.
  - On mem_rvalid = 1: drive owner_rvalid = 1 and owner_rdata = mem_rdata combinationally this cycle, then go to IDLE.
  - The non-owner's rvalid stays 0; its rdata is don't-care and is driven to 0.
- Latency with zero-wait memory:
  - Request sampled in IDLE at cycle 0.
  - mem_req and gnt in cycle 1.
  - rvalid in cycle 2.
  - Next arbitration in cycle 3. Store throughput is 1 per 2 cycles.
- Requester rule: a requester must deassert req, or present a new request, in the cycle after its gnt. A req that is still high after gnt is treated as a new request.
- is_stall = (if_req & ~if_gnt) | (ls_req & ~ls_gnt). It is combinational and asserts also during WAIT and IDLE.
- mem_rvalid in IDLE or REQ is a protocol error and is ignored. A simulation-only assertion flags it.

Decomposition:
- Package mem_arb_pkg holds:
  - state enum {IDLE, REQ, WAIT}
  - owner enum {NONE, IF, LS}
  - default width localparams
- One sub-module, arb_starve_ctr, implements the saturating counter. Inputs: ls_win_with_if_pending, if_win, if_idle_clear. Output: force_if.

Test Plan:
- Single fetch: if_req = 1, if_addr = 0x100, mem_ready = 1, mem_rvalid = 1 with rdata 0xDEADBEEF one cycle later -> mem_addr = 0x100 in cycle 1, if_gnt in cycle 1, if_rvalid with 0xDEADBEEF in cycle 2, ls_* quiet.
- Simultaneous requests: if_req and ls_req (load of 0x2000) both held -> LS is served first. With MAX_LS_BURST = 4 and LS requesting continuously, the IF grant occurs after exactly 4 LS grants.
- Store: ls_we = 1, addr 0x1000_0000, wdata 0x41, wstrb 0x1 -> mem_we = 1, mem_wstrb = 0x1, ls_gnt once, no ls_rvalid, FSM back in IDLE 1 cycle after gnt.
- Backpressure: mem_ready held 0 for 5 cycles -> mem_req and payload stable for 5 cycles, is_stall = 1 throughout, gnt only in the cycle mem_ready rises.
- Reset in WAIT: assert rst before mem_rvalid, then deliver a stale mem_rvalid after release -> no rvalid on either side, mem_req = 0, next request handled normally.
- Idle clear: LS wins 3 times while IF is pending, IF drops req for one IDLE cycle, then both request again -> counter is 0 and LS wins.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the memory-port arbiter.
package mem_arb_pkg;

  localparam int unsigned ADDR_W_DEF       = 32;
  localparam int unsigned DATA_W_DEF       = 32;
  localparam int unsigned MAX_LS_BURST_DEF = 4;

  // Transaction phase of the single shared memory port.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } arb_state_e;

  // Requester that owns the transaction currently in flight.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_LS   = 2'd2
  } arb_owner_e;

endpackage

// File: rtl/arb_starve_ctr.sv
// Saturating count of consecutive LS wins taken while IF is waiting.
// force_if asserts once the count reaches MAX_LS_BURST so IF wins the next tie.
module arb_starve_ctr
  import mem_arb_pkg::*;
#(
  parameter int unsigned MAX_LS_BURST = MAX_LS_BURST_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic ls_win_with_if_pending,
  input  logic if_win,
  input  logic if_idle_clear,
  output logic force_if
);

  localparam int unsigned       CNT_W   = $clog2(MAX_LS_BURST + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(MAX_LS_BURST);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next count: clear on IF progress or IF idle, otherwise saturating increment.
  always_comb begin
    cnt_d = cnt_q;
    if (if_win || if_idle_clear) begin
      cnt_d = '0;
    end else if (ls_win_with_if_pending && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign force_if = (cnt_q == CNT_MAX);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch (IF) and load/store (LS).
// One outstanding transaction, LS priority with a bounded IF starvation window.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W       = ADDR_W_DEF,
  parameter int unsigned DATA_W       = DATA_W_DEF,
  parameter int unsigned MAX_LS_BURST = MAX_LS_BURST_DEF
) (
  input  logic                clk,
  input  logic                rst,
  // fetch requester
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_gnt,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,
  // load/store requester
  input  logic                ls_req,
  input  logic                ls_we,
  input  logic [ADDR_W-1:0]   ls_addr,
  input  logic [DATA_W-1:0]   ls_wdata,
  input  logic [DATA_W/8-1:0] ls_wstrb,
  output logic                ls_gnt,
  output logic                ls_rvalid,
  output logic [DATA_W-1:0]   ls_rdata,
  // memory / MMIO side
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wstrb,
  input  logic                mem_ready,
  input  logic                mem_rvalid,
  input  logic [DATA_W-1:0]   mem_rdata,
  // next-PC stall
  output logic                is_stall
);

  localparam int unsigned STRB_W = DATA_W / 8;

  arb_state_e          state_q, state_d;
  arb_owner_e          owner_q, owner_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [STRB_W-1:0]   mem_wstrb_q, mem_wstrb_d;

  logic ls_win;
  logic if_win;
  logic force_if;

  arb_starve_ctr #(
    .MAX_LS_BURST(MAX_LS_BURST)
  ) u_starve (
    .clk                   (clk),
    .rst                   (rst),
    .ls_win_with_if_pending(ls_win & if_req),
    .if_win                (if_win),
    .if_idle_clear         ((state_q == S_IDLE) & ~if_req),
    .force_if              (force_if)
  );

  // Winner selection in IDLE: LS first unless IF has waited out the burst.
  always_comb begin
    ls_win = 1'b0;
    if_win = 1'b0;
    if (state_q == S_IDLE) begin
      if (ls_req && !(if_req && force_if)) begin
        ls_win = 1'b1;
      end else if (if_req) begin
        if_win = 1'b1;
      end
    end
  end

  // Next-state and payload latch for the single outstanding transaction.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wstrb_d = mem_wstrb_q;
    case (state_q)
      S_IDLE: begin
        if (ls_win) begin
          state_d     = S_REQ;
          owner_d     = OWN_LS;
          mem_we_d    = ls_we;
          mem_addr_d  = ls_addr;
          mem_wdata_d = ls_wdata;
          mem_wstrb_d = ls_wstrb;
        end else if (if_win) begin
          state_d     = S_REQ;
          owner_d     = OWN_IF;
          mem_we_d    = 1'b0;
          mem_addr_d  = if_addr;
          mem_wdata_d = '0;
          mem_wstrb_d = '1;
        end
      end
      S_REQ: begin
        if (mem_ready) begin
          if (mem_we_q) begin
            state_d = S_IDLE;
            owner_d = OWN_NONE;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (mem_rvalid) begin
          state_d = S_IDLE;
          owner_d = OWN_NONE;
        end
      end
      default: begin
        state_d = S_IDLE;
        owner_d = OWN_NONE;
      end
    endcase
  end

  // State, owner and memory payload registers; reset aborts any transaction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      owner_q     <= OWN_NONE;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wstrb_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wstrb_q <= mem_wstrb_d;
    end
  end

  // Grant and read-return steering to the owner; non-owner outputs stay 0.
  always_comb begin
    if_gnt    = 1'b0;
    ls_gnt    = 1'b0;
    if_rvalid = 1'b0;
    ls_rvalid = 1'b0;
    if_rdata  = '0;
    ls_rdata  = '0;
    if ((state_q == S_REQ) && mem_ready) begin
      if_gnt = (owner_q == OWN_IF);
      ls_gnt = (owner_q == OWN_LS);
    end
    if ((state_q == S_WAIT) && mem_rvalid) begin
      if (owner_q == OWN_IF) begin
        if_rvalid = 1'b1;
        if_rdata  = mem_rdata;
      end else if (owner_q == OWN_LS) begin
        ls_rvalid = 1'b1;
        ls_rdata  = mem_rdata;
      end
    end
  end

  assign mem_req   = (state_q == S_REQ);
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wstrb = mem_wstrb_q;
  assign is_stall  = (if_req & ~if_gnt) | (ls_req & ~ls_gnt);

  // A response to a transaction aborted by reset may still arrive before the
  // next request; only rvalid outside WAIT after that window is a protocol error.
  logic post_rst_q;

  // Tracks the quiet window between reset and the first new transaction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      post_rst_q <= 1'b1;
    end else if (state_q != S_IDLE) begin
      post_rst_q <= 1'b0;
    end
  end

  rvalid_outside_wait_a : assert property (
    @(posedge clk) disable iff (rst)
    !(mem_rvalid && (state_q != S_WAIT) && !post_rst_q)
  ) else $warning("mem_port_arbiter: mem_rvalid outside WAIT ignored");

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a transaction-level reference model.
module tb_mem_port_arbiter;

  localparam int unsigned AW   = 32;
  localparam int unsigned DW   = 32;
  localparam int unsigned SW   = DW / 8;
  localparam int          MAXB = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt, if_rvalid;
  logic [DW-1:0] if_rdata;
  logic          ls_req, ls_we;
  logic [AW-1:0] ls_addr;
  logic [DW-1:0] ls_wdata;
  logic [SW-1:0] ls_wstrb;
  logic          ls_gnt, ls_rvalid;
  logic [DW-1:0] ls_rdata;
  logic          mem_req, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [SW-1:0] mem_wstrb;
  logic          mem_ready, mem_rvalid;
  logic [DW-1:0] mem_rdata;
  logic          is_stall;

  // memory response source: manual from the stimulus, or automatic from the model
  logic          auto_rsp;
  logic          man_rvalid, rsp_v;
  logic [DW-1:0] man_rdata, rsp_d;
  assign mem_rvalid = auto_rsp ? rsp_v : man_rvalid;
  assign mem_rdata  = auto_rsp ? rsp_d : man_rdata;

  mem_port_arbiter #(
    .ADDR_W      (AW),
    .DATA_W      (DW),
    .MAX_LS_BURST(MAXB)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_gnt    (if_gnt),
    .if_rvalid (if_rvalid),
    .if_rdata  (if_rdata),
    .ls_req    (ls_req),
    .ls_we     (ls_we),
    .ls_addr   (ls_addr),
    .ls_wdata  (ls_wdata),
    .ls_wstrb  (ls_wstrb),
    .ls_gnt    (ls_gnt),
    .ls_rvalid (ls_rvalid),
    .ls_rdata  (ls_rdata),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wstrb (mem_wstrb),
    .mem_ready (mem_ready),
    .mem_rvalid(mem_rvalid),
    .mem_rdata (mem_rdata),
    .is_stall  (is_stall)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  task automatic chk1(input string name, input logic act, input logic exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (one pending transaction record) ----------
  bit            m_busy    = 1'b0;   // a transaction is in flight
  bit            m_granted = 1'b0;   // memory accepted it, read data still due
  int            m_who     = 0;      // 1 = IF, 2 = LS
  bit            m_we      = 1'b0;
  logic [AW-1:0] m_addr    = '0;
  logic [DW-1:0] m_wdata   = '0;
  logic [SW-1:0] m_wstrb   = '0;
  int            m_starve  = 0;

  always @(negedge clk) begin
    bit e_req, e_ifg, e_lsg, e_ifv, e_lsv, e_stall;
    if (rst) begin
      m_busy    = 1'b0;
      m_granted = 1'b0;
      m_starve  = 0;
    end
    e_req   = m_busy && !m_granted;
    e_ifg   = e_req && mem_ready && (m_who == 1);
    e_lsg   = e_req && mem_ready && (m_who == 2);
    e_ifv   = m_busy && m_granted && mem_rvalid && (m_who == 1);
    e_lsv   = m_busy && m_granted && mem_rvalid && (m_who == 2);
    e_stall = (if_req && !e_ifg) || (ls_req && !e_lsg);
    chk1("mdl_mem_req", mem_req, e_req);
    chk1("mdl_if_gnt", if_gnt, e_ifg);
    chk1("mdl_ls_gnt", ls_gnt, e_lsg);
    chk1("mdl_if_rvalid", if_rvalid, e_ifv);
    chk1("mdl_ls_rvalid", ls_rvalid, e_lsv);
    chk1("mdl_is_stall", is_stall, e_stall);
    if (e_req) begin
      chk32("mdl_mem_addr", mem_addr, m_addr);
      chk1("mdl_mem_we", mem_we, m_we);
      chk32("mdl_mem_wstrb", 32'(mem_wstrb), 32'(m_wstrb));
      if (m_we) chk32("mdl_mem_wdata", mem_wdata, m_wdata);
    end
    if (e_ifv) begin
      chk32("mdl_if_rdata", if_rdata, mem_rdata);
      chk32("mdl_ls_rdata_quiet", ls_rdata, 32'h0);
    end
    if (e_lsv) begin
      chk32("mdl_ls_rdata", ls_rdata, mem_rdata);
      chk32("mdl_if_rdata_quiet", if_rdata, 32'h0);
    end
    // advance to the state seen after the coming rising edge
    if (!rst) begin
      if (!m_busy) begin
        if (ls_req && !(if_req && (m_starve == MAXB))) begin
          m_busy = 1'b1; m_granted = 1'b0; m_who = 2;
          m_we = ls_we; m_addr = ls_addr; m_wdata = ls_wdata; m_wstrb = ls_wstrb;
          if (if_req) m_starve = (m_starve < MAXB) ? m_starve + 1 : MAXB;
        end else if (if_req) begin
          m_busy = 1'b1; m_granted = 1'b0; m_who = 1;
          m_we = 1'b0; m_addr = if_addr; m_wstrb = '1;
          m_starve = 0;
        end
        if (!if_req) m_starve = 0;
      end else if (!m_granted) begin
        if (mem_ready) begin
          if (m_we) m_busy = 1'b0;
          else      m_granted = 1'b1;
        end
      end else if (mem_rvalid) begin
        m_busy    = 1'b0;
        m_granted = 1'b0;
      end
    end
  end

  // automatic memory: return data in the cycle after a read is accepted
  always @(posedge clk) begin
    #1;
    rsp_v = m_busy && m_granted;
    rsp_d = m_addr ^ 32'hA5A5_0000;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // run cycles until IF is granted or LS reaches ls_limit grants
  task automatic run_grants(input int ls_limit, output int nls, output int nif, output int first);
    nls = 0; nif = 0; first = 0;
    for (int c = 0; c < 100; c++) begin
      tick();
      #2;
      if (ls_gnt) begin nls++; if (first == 0) first = 2; end
      if (if_gnt) begin nif++; if (first == 0) first = 1; end
      if ((nif > 0) || (nls >= ls_limit)) return;
    end
    vectors++;
    miscompares++;
    $display("FAIL grant_timeout: no end condition within 100 cycles (ls=%0d if=%0d)", nls, nif);
  endtask

  initial begin
    #100000;
    miscompares++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    int nls, nif, first;
    rst = 1'b1; if_req = 1'b0; if_addr = '0;
    ls_req = 1'b0; ls_we = 1'b0; ls_addr = '0; ls_wdata = '0; ls_wstrb = '0;
    mem_ready = 1'b0; man_rvalid = 1'b0; man_rdata = '0; auto_rsp = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    chk1("rst_mem_req", mem_req, 1'b0);
    chk1("rst_mem_we", mem_we, 1'b0);
    chk32("rst_mem_addr", mem_addr, 32'h0);
    chk32("rst_mem_wdata", mem_wdata, 32'h0);
    chk32("rst_mem_wstrb", 32'(mem_wstrb), 32'h0);
    tick(); rst = 1'b0;
    tick();

    // single fetch, zero-wait memory
    tick(); if_req = 1'b1; if_addr = 32'h100; mem_ready = 1'b1; #2;
    chk1("fetch_c0_mem_req", mem_req, 1'b0);
    chk1("fetch_c0_stall", is_stall, 1'b1);
    tick(); #2;
    chk32("fetch_c1_addr", mem_addr, 32'h100);
    chk1("fetch_c1_gnt", if_gnt, 1'b1);
    chk1("fetch_c1_we", mem_we, 1'b0);
    chk32("fetch_c1_wstrb", 32'(mem_wstrb), 32'hF);
    chk1("fetch_c1_ls_gnt", ls_gnt, 1'b0);
    tick(); if_req = 1'b0; man_rvalid = 1'b1; man_rdata = 32'hDEAD_BEEF; #2;
    chk1("fetch_c2_rvalid", if_rvalid, 1'b1);
    chk32("fetch_c2_rdata", if_rdata, 32'hDEAD_BEEF);
    chk1("fetch_c2_ls_rvalid", ls_rvalid, 1'b0);
    chk32("fetch_c2_ls_rdata", ls_rdata, 32'h0);
    tick(); man_rvalid = 1'b0; man_rdata = '0; #2;
    chk1("fetch_c3_rvalid", if_rvalid, 1'b0);

    // both requesting: LS first, IF after exactly MAXB LS grants
    tick(); if_req = 1'b1; if_addr = 32'h300; ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h2000;
    auto_rsp = 1'b1;
    run_grants(1000, nls, nif, first);
    chk32("arb_first_winner", 32'(first), 32'd2);
    chk32("arb_ls_before_if", 32'(nls), 32'd4);
    chk32("arb_if_granted", 32'(nif), 32'd1);
    tick(); if_req = 1'b0; ls_req = 1'b0;
    tick();
    tick(); auto_rsp = 1'b0;

    // store: granted once, no read return, next store one cycle later
    tick(); ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h1000_0000; ls_wdata = 32'h41; ls_wstrb = 4'h1;
    tick(); #2;
    chk1("st_we", mem_we, 1'b1);
    chk32("st_wstrb", 32'(mem_wstrb), 32'h1);
    chk32("st_addr", mem_addr, 32'h1000_0000);
    chk32("st_wdata", mem_wdata, 32'h41);
    chk1("st_gnt", ls_gnt, 1'b1);
    tick(); ls_addr = 32'h1000_0004; ls_wdata = 32'h42; #2;
    chk1("st_idle_after_gnt", mem_req, 1'b0);
    chk1("st_no_rvalid", ls_rvalid, 1'b0);
    tick(); #2;
    chk1("st2_mem_req", mem_req, 1'b1);
    chk32("st2_wdata", mem_wdata, 32'h42);
    chk1("st2_gnt", ls_gnt, 1'b1);
    tick(); ls_req = 1'b0; ls_we = 1'b0; #2;
    chk1("st2_no_rvalid", ls_rvalid, 1'b0);

    // backpressure: five not-ready cycles
    tick(); if_req = 1'b1; if_addr = 32'h400; mem_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick(); #2;
      chk1("bp_mem_req", mem_req, 1'b1);
      chk32("bp_addr", mem_addr, 32'h400);
      chk1("bp_no_gnt", if_gnt, 1'b0);
      chk1("bp_stall", is_stall, 1'b1);
    end
    tick(); mem_ready = 1'b1; #2;
    chk1("bp_gnt", if_gnt, 1'b1);
    chk1("bp_stall_release", is_stall, 1'b0);
    tick(); if_req = 1'b0; man_rvalid = 1'b1; man_rdata = 32'h1234_5678; #2;
    chk32("bp_rdata", if_rdata, 32'h1234_5678);
    tick(); man_rvalid = 1'b0;

    // reset while a load waits for data, then a stale response
    tick(); ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h2000;
    tick(); #2;
    chk1("rw_gnt", ls_gnt, 1'b1);
    tick(); ls_req = 1'b0; rst = 1'b1; #2;
    chk1("rw_rst_mem_req", mem_req, 1'b0);
    chk1("rw_rst_rvalid", ls_rvalid, 1'b0);
    tick(); rst = 1'b0; man_rvalid = 1'b1; man_rdata = 32'hBAD0_BAD0; #2;
    chk1("rw_stale_ls_rvalid", ls_rvalid, 1'b0);
    chk1("rw_stale_if_rvalid", if_rvalid, 1'b0);
    chk1("rw_stale_mem_req", mem_req, 1'b0);
    tick(); man_rvalid = 1'b0; if_req = 1'b1; if_addr = 32'h500;
    tick(); #2;
    chk1("rw_next_gnt", if_gnt, 1'b1);
    chk32("rw_next_addr", mem_addr, 32'h500);
    tick(); if_req = 1'b0; man_rvalid = 1'b1; man_rdata = 32'h55; #2;
    chk32("rw_next_rdata", if_rdata, 32'h55);
    tick(); man_rvalid = 1'b0;

    // idle clear: 3 LS wins, IF drops for one IDLE cycle, counter restarts
    tick(); if_req = 1'b1; if_addr = 32'h600; ls_req = 1'b1; ls_addr = 32'h3000; auto_rsp = 1'b1;
    run_grants(3, nls, nif, first);
    chk32("ic_ls_wins", 32'(nls), 32'd3);
    chk32("ic_no_if", 32'(nif), 32'd0);
    tick(); if_req = 1'b0; ls_req = 1'b0;
    tick(); #2;
    chk1("ic_idle", mem_req, 1'b0);
    tick(); if_req = 1'b1; ls_req = 1'b1;
    run_grants(1000, nls, nif, first);
    chk32("ic_first_winner", 32'(first), 32'd2);
    chk32("ic_ls_before_if", 32'(nls), 32'd4);
    tick(); if_req = 1'b0; ls_req = 1'b0;
    tick();
    tick(); auto_rsp = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
